reg_write_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 8-bit enable-gated register (ff_en style:
//   en/d captured on posedge clk) among NREQ requesters. Picks one requester,

---
 rtl/reg_write_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one enable-gated DW-bit register.
// Latency: req sampled at edge E -> reg_en E..E+1, ack E+1..E+2, next grant from E+3.
// Backpressure: losers hold req (level) and wait; at most one write in flight, 1 per 3 cycles.
module reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic                 reg_en,
    output logic [DW-1:0]        reg_d,
    output logic                 busy,
    output logic [IW-1:0]        last_id,
    output logic [7:0]           wr_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              reg_en_q, reg_en_d;
    logic [DW-1:0]     reg_d_q, reg_d_d;
    logic              busy_q, busy_d;
    logic [IW-1:0]     last_id_q, last_id_d;
    logic [7:0]        wr_count_q, wr_count_d;

    logic [DW-1:0]     data_arr [NREQ];
    logic [IW-1:0]     win_idx;
    logic              win_vld;
    logic [IW-1:0]     cand;
    logic [NREQ-1:0]   win_oh;

    // Split the flat request data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    // Round-robin pick: scan from last_id+1 upward with wrap. The loop runs from the
    // lowest-priority offset to the highest so the last hit is the rightful winner.
    always_comb begin
        win_idx = last_id_q;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_id_q) + k) % NREQ);
            if (req[cand]) begin
                win_idx = cand;
                win_vld = 1'b1;
            end
        end
        win_oh = NREQ'(1) << win_idx;
    end

    // Next-state and registered-output logic for the IDLE -> WRITE -> ACK cycle.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        reg_en_d   = 1'b0;
        reg_d_d    = reg_d_q;
        last_id_d  = last_id_q;
        wr_count_d = wr_count_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    gnt_d     = win_oh;
                    reg_d_d   = data_arr[win_idx];
                    reg_en_d  = 1'b1;
                    last_id_d = win_idx;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Register captures reg_d at the end of this cycle; tell the winner next.
                ack_d   = gnt_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                gnt_d      = '0;
                wr_count_d = wr_count_q + 8'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any write in progress without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            reg_en_q   <= 1'b0;
            reg_d_q    <= '0;
            busy_q     <= 1'b0;
            last_id_q  <= IW'(NREQ - 1);
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            reg_en_q   <= reg_en_d;
            reg_d_q    <= reg_d_d;
            busy_q     <= busy_d;
            last_id_q  <= last_id_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign reg_en   = reg_en_q;
    assign reg_d    = reg_d_q;
    assign busy     = busy_q;
    assign last_id  = last_id_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: random requester agents against a cycle-count reference model.
// Model tracks the edge of the last grant and derives expected outputs from the offset.
// Requesters hold req until their ack, then may re-request after a random delay.
module tb_reg_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              reg_en;
    logic [DW-1:0]     reg_d;
    logic              busy;
    logic [1:0]        last_id;
    logic [7:0]        wr_count;

    // Controlled register: plain enable-gated flop fed by the arbiter.
    logic [DW-1:0]     ext_q = 8'h00;

    reg_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .ack      (ack),
        .reg_en   (reg_en),
        .reg_d    (reg_d),
        .busy     (busy),
        .last_id  (last_id),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_en) ext_q <= reg_d;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          t;          // posedge count
    int          g_edge;     // edge at which the current/last grant was made
    int          m_win;      // winner index, -1 if none yet
    logic [1:0]  m_last;
    int          m_cnt;      // completed writes (unwrapped)
    logic [7:0]  m_data;
    logic [7:0]  m_q;
    int          rate;
    bit          wrap_seen;
    int          wait_cnt [NREQ];
    logic [3:0]  gnt_prev;

    task automatic model_reset();
        g_edge = -100;
        m_win  = -1;
        m_last = 2'(NREQ - 1);
        m_cnt  = 0;
        m_data = 8'h00;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        gnt_prev = 4'h0;
    endtask

    // One clock: drive at negedge, let the edge happen, update model, check at edge+1.
    task automatic step();
        int ph;
        int w;
        logic [3:0]  req_s;
        logic [31:0] data_s;
        logic [3:0]  oh;
        ph = t - g_edge;
        for (int i = 0; i < NREQ; i++) begin
            if (ph == 1 && i == m_win) begin
                req[i] = 1'b0;
            end else if (ph <= 1 && i == m_win) begin
                // Data changes after the grant edge must not reach the register.
                if ($urandom_range(1, 0) == 1) req_data[i*DW +: DW] = 8'($urandom);
            end else if (!req[i] && rate > 0 && int'($urandom_range(99, 0)) < rate) begin
                req[i] = 1'b1;
                req_data[i*DW +: DW] = 8'($urandom);
            end
        end
        req_s  = req;
        data_s = req_data;
        @(posedge clk);
        t++;
        if (t >= g_edge + 3) begin
            if (req_s != 4'h0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (int'(m_last) + k) % NREQ;
                    if (w < 0 && req_s[c]) w = c;
                end
                g_edge = t;
                m_win  = w;
                m_last = 2'(w);
                m_data = data_s[w*DW +: DW];
            end
        end else if (t == g_edge + 1) begin
            m_q = m_data;
        end else if (t == g_edge + 2) begin
            m_cnt++;
        end
        #1;
        ph = t - g_edge;
        oh = (m_win >= 0) ? 4'(1 << m_win) : 4'h0;
        chk("gnt",      32'(gnt),      32'((ph <= 1) ? oh : 4'h0));
        chk("ack",      32'(ack),      32'((ph == 1) ? oh : 4'h0));
        chk("reg_en",   32'(reg_en),   32'(ph == 0));
        chk("busy",     32'(busy),     32'(ph <= 1));
        chk("reg_d",    32'(reg_d),    32'(m_data));
        chk("last_id",  32'(last_id),  32'(m_last));
        chk("wr_count", 32'(wr_count), 32'(m_cnt % 256));
        chk("reg_q",    32'(ext_q),    32'(m_q));
        if (ph == 2 && m_cnt == 256) begin
            wrap_seen = 1'b1;
            chk("wrap", 32'(wr_count), 32'h0);
        end
        // Fairness measured on the DUT's own grants.
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) wait_cnt[i] = 0;
        end
        if (gnt_prev == 4'h0 && gnt != 4'h0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    chk("fair", 32'(wait_cnt[i] <= NREQ - 1), 32'h1);
                    wait_cnt[i] = 0;
                end else if (req[i]) begin
                    wait_cnt[i]++;
                end
            end
        end
        gnt_prev = gnt;
        @(negedge clk);
    endtask

    initial begin
        int guard;
        bit hit;
        t = 0;
        m_q = 8'h00;
        wrap_seen = 1'b0;
        rate = 0;
        model_reset();
        rst = 1'b1;
        req = 4'hF;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'($urandom);

        // Reset with every requester asserted
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",     32'(gnt),      32'h0);
        chk("rst_reg_en",  32'(reg_en),   32'h0);
        chk("rst_ack",     32'(ack),      32'h0);
        chk("rst_last_id", 32'(last_id),  32'h3);
        chk("rst_wr_cnt",  32'(wr_count), 32'h0);
        chk("rst_busy",    32'(busy),     32'h0);
        rst = 1'b0;

        // First grant goes to req[0]; all four then served in order
        step();
        chk("first_gnt", 32'(gnt), 32'h1);
        repeat (13) step();

        // Single directed write from requester 2
        req[2] = 1'b1;
        req_data[2*DW +: DW] = 8'hA5;
        step();
        chk("t2_reg_en", 32'(reg_en), 32'h1);
        chk("t2_reg_d",  32'(reg_d),  32'hA5);
        step();
        chk("t2_reg_q",  32'(ext_q),  32'hA5);
        chk("t2_ack",    32'(ack),    32'h4);
        step();
        chk("t2_wr_cnt", 32'(wr_count), 32'h5);

        // Full contention: everyone re-requests immediately
        rate = 100;
        repeat (60) step();

        // Random traffic at varying request rates
        for (int blk = 0; blk < 20; blk++) begin
            rate = int'($urandom_range(100, 20));
            repeat (50) step();
        end

        // Keep saturating until the counter has wrapped
        rate = 100;
        guard = 0;
        while (m_cnt < 260 && guard < 3000) begin
            step();
            guard++;
        end

        // Reset in the middle of a write
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step();
            if (t == g_edge) hit = 1'b1;
        end
        chk("rst_mid_reach", 32'(hit), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_reg_en",  32'(reg_en),   32'h0);
        chk("mid_gnt",     32'(gnt),      32'h0);
        chk("mid_ack",     32'(ack),      32'h0);
        chk("mid_busy",    32'(busy),     32'h0);
        chk("mid_wr_cnt",  32'(wr_count), 32'h0);
        chk("mid_last_id", 32'(last_id),  32'h3);
        model_reset();
        @(posedge clk);
        t++;
        #1;
        chk("mid_no_ack",    32'(ack),    32'h0);
        chk("mid_no_reg_en", 32'(reg_en), 32'h0);
        chk("mid_reg_q",     32'(ext_q),  32'(m_q));
        @(negedge clk);
        rst = 1'b0;

        // Normal operation after the aborted write
        rate = 50;
        repeat (100) step();

        chk("wrap_seen", 32'(wrap_seen), 32'h1);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
